// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CKSUM, SETTLE, RUN} loader_state_t;

  localparam int LOADER_ADDR_W = 8;
  localparam int LOADER_DATA_W = 32;

endpackage

// File: rtl/prog_loader.sv
// Streams program words into instruction memory while holding the core in reset.
// Optional checksum word after the payload: define PROG_LOADER_CKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = LOADER_ADDR_W,
  parameter int DATA_W     = LOADER_DATA_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_n_rst,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              err_cksum
);

  localparam logic [ADDR_W:0] DEPTH       = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE         = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYC);
`ifdef PROG_LOADER_CKSUM_EN
  localparam loader_state_t   AFTER_LOAD  = CKSUM;
`else
  localparam loader_state_t   AFTER_LOAD  = SETTLE;
`endif

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] cnt_q, addr_q, cnt_new, addr_inc;
  logic [3:0]      settle_q;
  logic            start_acc, ovf_new, hs, load_done;
  logic            done_q, err_ovf_q;

  // start is only honoured when not busy; RUN restarts a fresh load
  assign start_acc = start && (state_q == IDLE || state_q == RUN);
  assign ovf_new   = word_count > DEPTH;
  assign cnt_new   = ovf_new ? DEPTH : word_count;
  assign addr_inc  = addr_q + ONE;

`ifdef PROG_LOADER_CKSUM_EN
  assign in_ready  = ((state_q == LOAD) && (addr_q < cnt_q)) || (state_q == CKSUM);
`else
  assign in_ready  = (state_q == LOAD) && (addr_q < cnt_q);
`endif
  assign hs        = in_valid && in_ready;
  assign load_done = (state_q == LOAD) && hs && (addr_inc == cnt_q);

`ifdef PROG_LOADER_CKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              err_cksum_q, cksum_ok;

  assign cksum_ok  = (in_data == sum_q);
  assign err_cksum = err_cksum_q;

  always_ff @(posedge clk) begin
    if (start_acc)
      sum_q <= '0;
    else if (state_q == LOAD && hs)
      sum_q <= sum_q + in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cksum_q <= 1'b0;
    else if (start_acc)
      err_cksum_q <= 1'b0;
    else if (state_q == CKSUM && hs && !cksum_ok)
      err_cksum_q <= 1'b1;
  end
`else
  assign err_cksum = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: if (start) state_d = (cnt_new == '0) ? AFTER_LOAD : LOAD;
      LOAD:      if (load_done) state_d = AFTER_LOAD;
      CKSUM: begin
`ifdef PROG_LOADER_CKSUM_EN
        if (hs) state_d = cksum_ok ? SETTLE : IDLE;
`else
        state_d = IDLE;
`endif
      end
      SETTLE:    if (settle_q <= 4'd1) state_d = RUN;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == RUN) && (state_q != RUN);
      if (start_acc) begin
        cnt_q     <= cnt_new;
        addr_q    <= '0;
        err_ovf_q <= ovf_new;
      end else if (state_q == LOAD && hs) begin
        addr_q <= addr_inc;
      end
      // SETTLE lasts exactly SETTLE_CYC cycles
      if (state_d == SETTLE && state_q != SETTLE)
        settle_q <= SETTLE_INIT;
      else if (state_q == SETTLE)
        settle_q <= settle_q - 4'd1;
    end
  end

  assign imem_we    = hs && (state_q == LOAD);
  assign imem_waddr = addr_q[ADDR_W-1:0];
  assign imem_wdata = in_data;
  assign busy       = state_q inside {LOAD, CKSUM, SETTLE};
  assign core_n_rst = (state_q == RUN) && !rst;
  assign done       = done_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Streams program words into instruction memory and controls the core reset around the load.
- Holds the core in reset, accepts N words over a valid/ready stream, and writes them to consecutive word addresses starting at 0.
- After a fixed settle delay, releases the core.
- Sits between an external boot source (UART/JTAG front end) and instruction memory's write port. This gives silicon a hardware path for loading programs.

Parameters:
- ADDR_W, 8: instruction memory word-address width (depth 2^ADDR_W words).
- DATA_W, 32: instruction word width.
- SETTLE_CYC, 2: cycles between the last write and core reset release (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load of word_count words.
- word_count  in  ADDR_W+1  number of words to load. Sampled when start is accepted.
- in_valid  in  1  source presents in_data.
- in_data  in  DATA_W  program word.
- in_ready  out  1  loader accepts in_data this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  word address to write.
- imem_wdata  out  DATA_W  word to write.
- core_n_rst  out  1  active-low reset to the core; 0 holds the core.
- busy  out  1  high in LOAD and SETTLE.
- done  out  1  one-cycle pulse on release of core_n_rst.
- err_ovf  out  1  sticky; word_count exceeded 2^ADDR_W. Cleared by the next accepted start.

Behaviour:
- Reset values: state=IDLE; core_n_rst=0; in_ready=0; imem_we=0; imem_waddr=0; busy=0; done=0; err_ovf=0.
- IDLE:
  - core held (core_n_rst=0).
  - start=1 → latch cnt_q=min(word_count, 2^ADDR_W); set err_ovf if word_count>2^ADDR_W; addr_q=0.
  - Next state is LOAD, or SETTLE if cnt_q==0.
- LOAD:
  - in_ready=1 when addr_q<cnt_q.
  - Handshake = in_valid&&in_ready.
  - imem_we=handshake (combinational, zero latency); imem_waddr=addr_q; imem_wdata=in_data.
  - On handshake addr_q++.
  - On the handshake that makes addr_q==cnt_q → SETTLE.
  - in_valid low: stall indefinitely, no writes.
- SETTLE:
  - Down-counter loaded with SETTLE_CYC; in_ready=0; core still held.
  - At 0 → RUN.
- RUN:
  - core_n_rst=1; done=1 on the first RUN cycle only; busy=0; in_ready=0.
  - start=1 → reassert core_n_rst=0 the next cycle and behave as start from IDLE (reload).
- start while busy: ignored.
- Full depth (word_count=2^ADDR_W): last write at addr 2^ADDR_W-1.
  - addr_q is ADDR_W+1 bits wide; imem_waddr is its low ADDR_W bits, so there is no wrap before completion.
- Words presented after cnt_q reached: not accepted (in_ready=0).
- rst mid-load: immediate return to IDLE, all outputs to reset values; partially written memory is left as is.
- Cycle count: a load of N words with continuous valid completes with core_n_rst rising N+SETTLE_CYC+1 cycles after the start cycle.

Optional Feature:
- Macro: PROG_LOADER_CKSUM_EN.
- Defined:
  - LOAD accumulates a DATA_W-bit wrapping sum of accepted words.
  - After the last data word, a CKSUM state accepts one extra word (in_ready=1) without writing memory.
  - Match → SETTLE.
  - Mismatch → sticky err_cksum=1; return to IDLE with core held; done not pulsed.
  - err_cksum clears on the next accepted start.
  - word_count=0 still expects a checksum word of 0.
- Not defined: no CKSUM state; err_cksum port present and tied 0.

Decomposition:
- Package loader_pkg holds:
  - typedef enum loader_state_t {IDLE, LOAD, CKSUM, SETTLE, RUN};
  - default widths: LOADER_ADDR_W=8, LOADER_DATA_W=32.
- No sub-module. The counters and FSM fit in one module. top instantiates it and ANDs core_n_rst with the system reset for the core.

Test Plan:
- Reset then start with word_count=4 and words 00A00093, 00500113, 002081B3, 40208233, continuous valid → writes at addr 0..3 with matching data; core_n_rst rises on cycle 4+SETTLE_CYC+1; done pulses once. The core then executes and RF[1]=10, RF[2]=5, RF[3]=15, RF[4]=5.
- Same load with in_valid toggling 1,0,0,1 per word → exactly 4 writes, no duplicate addresses, no write while in_valid=0.
- word_count=0 → no imem_we; core released after SETTLE_CYC+1 cycles.
- word_count=257 with ADDR_W=8 → err_ovf=1; 256 writes, last at addr FF; in_ready=0 afterward.
- Assert rst during the 3rd word → outputs return to reset values the same cycle; a new start reloads from addr 0. start in RUN → core_n_rst drops next cycle.
- With PROG_LOADER_CKSUM_EN: words 1,2,3 then checksum 6 → release. Checksum 7 → err_cksum=1, core_n_rst stays 0.
